// File: rtl/wb_ram_responder.sv
// wb_ram_responder: Wishbone responder over a 2^AW x RW-bit RAM; WB_RESP_ADDR_ERR_EN flags nonzero upper address bits with wb_err.
// Latency: strobe sampled -> ack registered after WAIT wait states; one beat every WAIT+2 cycles with stb held.
// Backpressure: master holds stb until ack/err; dropping wb_cyc before RESP abandons the beat with no side effects.
`ifndef RW
`define RW 16
`endif

module wb_ram_responder #(
  parameter int AW   = 8,
  parameter int WAIT = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           wb_cyc,
  input  logic           wb_stb,
  input  logic           wb_we,
  input  logic [`RW-1:0] wb_adr,
  input  logic [`RW-1:0] wb_i_dat,
  input  logic [1:0]     wb_sel,
  output logic [`RW-1:0] wb_o_dat,
  output logic           wb_ack,
  output logic           wb_err
);

  if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
    $error("wb_ram_responder: WAIT=%0d outside 0..15", WAIT);
  end
  if (AW < 1 || AW > `RW) begin : g_bad_aw
    $error("wb_ram_responder: AW=%0d outside 1..RW", AW);
  end

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      cnt;
  logic            req;
  logic            commit;

  logic [AW-1:0]   adr_q;
  logic            we_q;
  logic [`RW-1:0]  dat_q;
  logic [1:0]      sel_q;
  logic            bad_q;

  logic [AW-1:0]   cur_adr;
  logic            cur_we;
  logic [`RW-1:0]  cur_dat;
  logic [1:0]      cur_sel;
  logic            cur_bad;
  logic            bad_live;

  logic [`RW-1:0]  mem [2**AW];

  assign req = wb_cyc & wb_stb;

`ifdef WB_RESP_ADDR_ERR_EN
  if (AW < `RW) begin : g_adr_chk
    assign bad_live = |wb_adr[`RW-1:AW];
  end else begin : g_adr_full
    assign bad_live = 1'b0;
  end
`else
  // Upper address bits alias onto the RAM; they are deliberately ignored.
  logic unused_adr_hi;
  assign unused_adr_hi = ^wb_adr;
  assign bad_live      = 1'b0;
`endif

  // With WAIT == 0 the RESP entry edge is also the sampling edge, so the live bus stands in for the latch.
  always_comb begin
    cur_adr = adr_q;
    cur_we  = we_q;
    cur_dat = dat_q;
    cur_sel = sel_q;
    cur_bad = bad_q;
    if (state == S_IDLE) begin
      cur_adr = wb_adr[AW-1:0];
      cur_we  = wb_we;
      cur_dat = wb_i_dat;
      cur_sel = wb_sel;
      cur_bad = bad_live;
    end
  end

  // The beat commits on the edge that enters RESP; reset vetoes it.
  assign commit = i_rst_n & (state_nxt == S_RESP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = (WAIT == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wb_cyc) begin
          state_nxt = S_IDLE;
        end else if (cnt == 4'd1) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wb_ack = 1'b0;
    wb_err = 1'b0;
    if (state == S_RESP) begin
      wb_ack = ~bad_q;
      wb_err = bad_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt   <= 4'd0;
      adr_q <= '0;
      we_q  <= 1'b0;
      dat_q <= '0;
      sel_q <= 2'b00;
      bad_q <= 1'b0;
    end else if (state == S_IDLE && req) begin
      cnt   <= WAIT_CNT;
      adr_q <= wb_adr[AW-1:0];
      we_q  <= wb_we;
      dat_q <= wb_i_dat;
      sel_q <= wb_sel;
      bad_q <= bad_live;
    end else if (state == S_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (commit && cur_we && !cur_bad) begin
      if (cur_sel[0]) mem[cur_adr][7:0]  <= cur_dat[7:0];
      if (cur_sel[1]) mem[cur_adr][15:8] <= cur_dat[15:8];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wb_o_dat <= '0;
    end else if (commit && !cur_we && !cur_bad) begin
      wb_o_dat <= mem[cur_adr];
    end
  end

endmodule

// File: doc/wb_ram_responder.md
# wb_ram_responder

Wishbone responder that serves single-beat and burst reads/writes from an internal word-addressed RAM with a programmable number of wait states. Sits on the memory side of the instruction/data buses and answers the 8-beat line refills issued by the cache initiators, one `RW`-bit word per acknowledged strobe. Acknowledges are registered, so every beat has at least one cycle of latency.

## Interface
Parameters:
- AW, 8, word-address width; RAM depth is 2^AW words of `RW` bits.
- WAIT, 1, wait states inserted between strobe sampling and ack (0..15).

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- wb_cyc  in  1  bus cycle active.
- wb_stb  in  1  strobe; a beat is requested while wb_cyc & wb_stb.
- wb_we  in  1  1 = write, 0 = read.
- wb_adr  in  `RW  word address.
- wb_i_dat  in  `RW  write data.
- wb_sel  in  2  byte lane enables; [1] = bits 15:8, [0] = bits 7:0.
- wb_o_dat  out  `RW  read data; valid in the wb_ack cycle.
- wb_ack  out  1  one-cycle beat acknowledge.
- wb_err  out  1  one-cycle error terminate (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if wb_cyc & wb_stb, latch wb_adr, wb_we, wb_i_dat and wb_sel, and load the wait counter with WAIT. Go to RESP if WAIT == 0, else go to WAIT.
- WAIT: decrement the counter each cycle; when it reaches 1, go to RESP on the next edge.
- If wb_cyc falls in IDLE or WAIT, return to IDLE: no ack, no write.
- RESP entry edge, i.e. the edge on which wb_ack/wb_err is registered high:
  - Read: wb_o_dat <= mem[adr[AW-1:0]].
  - Write: mem updated per byte lane where wb_sel bit = 1; wb_o_dat unchanged.
  - wb_sel = 2'b00 write: acked, no RAM change.
- RESP: wb_ack (or wb_err) is high for exactly this cycle. Always go to IDLE next, even if wb_cyc has dropped; the beat has already committed.
- Request fields are taken only from the latched copy; bus changes during WAIT/RESP are ignored.
- RAM contents are not cleared by reset. The bench initialises them through writes.
- Counter is 4 bits; WAIT > 15 is illegal (elaboration error).

## Timing
- Reset values: wb_ack = 0, wb_err = 0, wb_o_dat = 0, state = IDLE, counter = 0. Reset is asynchronous, so asserting it mid-beat drops wb_ack immediately and discards any pending write.
- Beat latency: strobe sampled at edge N → wb_ack high during cycle N+1+WAIT.
- Beat period with stb held high: WAIT+2 cycles. The IDLE cycle after RESP samples the master's updated address.
- 8-beat burst at WAIT = 1: 24 cycles from the first sampled strobe to the last ack falling.
- Back-to-back write then read of the same address returns the new data. The write commits at the RESP entry edge, before the next IDLE sample.

## Configuration
- WB_RESP_ADDR_ERR_EN defined:
  - wb_adr bits above AW-1 are checked when the request is latched.
  - If any is nonzero, the beat terminates with wb_err instead of wb_ack, with identical timing.
  - No RAM write; wb_o_dat unchanged.
- Undefined: wb_err tied to 0; upper address bits ignored (addresses alias modulo 2^AW).

## Test plan
- Reset: drive i_rst_n = 0 asynchronously mid-WAIT with a write pending → wb_ack = 0 immediately; after release, reading that address shows the old value.
- Single write/read, WAIT = 0: write 16'hBEEF to adr 5, sel 2'b11 → ack one cycle after stb. Read adr 5 → wb_o_dat = 16'hBEEF in the ack cycle.
- Byte lanes: mem[3] = 16'h1234; write 16'hABCD, sel 2'b10 → read returns 16'hAB34. Then write with sel 2'b00 → still 16'hAB34.
- Burst, WAIT = 1: preload adr 0x10..0x17 with 0x100..0x107; hold stb high and advance adr on each ack → 8 acks spaced 3 cycles apart, data 0x100..0x107 in order, 24 cycles total.
- Abort: wb_cyc dropped during WAIT (WAIT = 3) on a write of 16'h5555 to adr 7 → no ack, mem[7] unchanged.
- With WB_RESP_ADDR_ERR_EN, AW = 8: read adr 16'h0100 → wb_err pulse, wb_ack = 0. Without the macro: ack, with data from adr 0.
